// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes and result-entry type shared by alu_core and alu_stream
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  typedef struct packed {
    logic [31:0] c;
    logic        zero;
    logic        err;
  } entry_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; A,B,ALUOp in -> C out, err flags opcodes 110/111 (which yield C=0)
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic [31:0] C,
  output logic        err
);
  assign err = ALUOp[2] & ALUOp[1];
  assign C = ALUOp == OP_ADD ? A + B :
             ALUOp == OP_SUB ? A - B :
             ALUOp == OP_AND ? A & B :
             ALUOp == OP_OR  ? A | B :
             ALUOp == OP_SRL ? A >> B[4:0] :
             ALUOp == OP_SRA ? 32'($signed(A) >>> B[4:0]) : '0;
endmodule

// File: rtl/alu_stream.sv
// alu_stream: valid/ready ALU front-end; in_valid/in_ready/A/B/ALUOp request side, out_valid/out_ready/C/zero/err result side via a DEPTH-entry in-order FIFO, count = occupancy
module alu_stream
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              A,
  input  logic [31:0]              B,
  input  logic [2:0]               ALUOp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              C,
  output logic                     zero,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  entry_t          mem [DEPTH];
  entry_t          wr_e;
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;
  logic [31:0]     core_c;
  logic            core_err, push, pop;
  alu_core u_core (.A(A), .B(B), .ALUOp(ALUOp), .C(core_c), .err(core_err));
  assign wr_e      = '{c: core_c, zero: core_c == '0, err: core_err};
  assign in_ready  = cnt != (AW+1)'(DEPTH);
  assign out_valid = cnt != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;
  assign C         = mem[rp].c;
  assign zero      = mem[rp].zero;
  assign err       = mem[rp].err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wp] <= wr_e;
      wp  <= push ? wp + 1'b1 : wp;
      rp  <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: doc/alu_stream.md
# alu_stream

Streaming front-end that accepts ALU requests over a valid/ready channel, evaluates them with a combinational `alu_core`, and returns results in order through a result FIFO with its own valid/ready channel. It replaces open-loop stimulus driving of the ALU inputs in the p1 datapath. Upstream issuers can stream operations back-to-back, and downstream consumers can apply backpressure.

## Interface
- `DEPTH`, default 4: result FIFO entries; must be a power of two and at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: a request is present on `A`/`B`/`ALUOp`.
- `in_ready` output 1: the block can accept a request this cycle.
- `A` input 32: operand A.
- `B` input 32: operand B.
- `ALUOp` input 3: operation select.
- `out_valid` output 1: the FIFO head holds a result.
- `out_ready` input 1: the consumer takes the head this cycle.
- `C` output 32: result at the FIFO head.
- `zero` output 1: `C == 0` for the head entry.
- `err` output 1: the head entry came from an illegal `ALUOp`.
- `count` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Opcodes:
  - 000: `A+B`, wraps modulo 2^32.
  - 001: `A-B`, wraps modulo 2^32.
  - 010: `A&B`.
  - 011: `A|B`.
  - 100: `A>>B[4:0]`, logical shift.
  - 101: `A>>>B[4:0]`, arithmetic shift; the sign comes from `A[31]`.
  - 110 and 111: illegal. Store `C=0` and `err=1`.
- `B[31:5]` is ignored for shifts. Carry and overflow are not reported.
- Accept (push) happens when `in_valid && in_ready`. The `alu_core` output for the current inputs is written into the FIFO tail as {C, zero, err}.
- Pop happens when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. There is no pass-through when full: a pop in a full cycle frees space starting the next cycle.
- `out_valid = (count != 0)`. There is no bypass: a result becomes visible no earlier than the cycle after its push.
- Push and pop in the same cycle: both take effect and `count` is unchanged. This holds for every `count` from 1 to DEPTH-1.
- The read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Ordering: results leave strictly in acceptance order.
- `C`/`zero`/`err` reflect the head entry while `out_valid=1`. They hold stable until a pop while `out_ready=0`.
- Inputs are ignored when `in_valid=0` or `in_ready=0`. `A`/`B`/`ALUOp` need only be valid in the accept cycle.

## Timing
- Reset, when `rst_n=0` at a rising edge:
  - pointers = 0 and `count=0`;
  - `out_valid=0` and `in_ready=1`;
  - `C`, `zero` and `err` read 0 (the head storage is cleared).
- Reset overrides a push or pop in the same cycle. Entries in flight are discarded.
- Latency: push at edge N, result at the head with `out_valid=1` after edge N if the FIFO was empty.
- Throughput: one request per cycle sustained while `out_ready=1`.
- `in_ready`, `out_valid` and `count` are derived from registered state only. No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- `in_ready` is independent of `out_ready` in the same cycle.

## Structure
- Package `alu_pkg` holds:
  - `ALUOp` localparams: `OP_ADD`=3'b000, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_SRL`, `OP_SRA`;
  - a result-entry typedef {C[31:0], zero, err}.
- Sub-module `alu_core` is purely combinational: `A`, `B`, `ALUOp` -> `C`, `err`. `zero` is computed in `alu_stream`.
- `alu_stream` contains:
  - the FIFO storage array;
  - the write and read pointers;
  - the occupancy counter;
  - the handshake logic.

## Test plan
- Reset then single add: A=1, B=2, ALUOp=000, one cycle -> next cycle `out_valid=1`, `C=3`, `zero=0`, `err=0`; pop -> `count=0`.
- Arithmetic edge cases:
  - sub with A=5, B=5 -> `C=0`, `zero=1`;
  - add with A=32'hFFFFFFFF, B=1 -> `C=0`;
  - sra with A=32'h80000000, B=32'h24 (shift 4) -> `C=32'hF8000000`;
  - srl with the same operands -> `C=32'h08000000`.
- Illegal op: ALUOp=110, A=7, B=9 -> `C=0`, `err=1`, `zero=1`.
- Backpressure: `out_ready=0`, issue 5 requests with DEPTH=4 -> first 4 accepted; `in_ready=0` and `count=4` after the 4th; the 5th is held off. With `out_ready=1` for one cycle, `in_ready=1` the next cycle and order is preserved (C values 10, 11, 12, 13).
- Simultaneous push/pop at `count=2` over 8+ cycles -> `count` stays 2, pointers wrap, results in order.
- Reset with 3 entries queued and `in_valid=1` -> next cycle `count=0`, `out_valid=0`, `in_ready=1`; the reset-cycle request is not stored.
